// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline-stage register: occupancy FSM encoding and counter widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_st_e;

  localparam int unsigned PIPE_PERF_W  = 32;
  localparam int unsigned PIPE_FLUSH_W = 16;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter, synchronously cleared by rst; used by pipe_stage_reg perf monitoring.
module pipe_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-stage register with optional 2-entry skid buffer, flush and hold.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble/flush performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PIPE_PERF_W-1:0]  perf_stall_cnt,
  output logic [PIPE_PERF_W-1:0]  perf_bubble_cnt,
  output logic [PIPE_FLUSH_W-1:0] perf_flush_cnt
`endif
);

  pipe_st_e          state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q;
  logic              out_valid_raw, in_xfer, out_xfer;

  assign out_valid_raw = (state_q != EMPTY);
  assign out_valid     = out_valid_raw & ~hold;
  assign out_data      = head_data_q;
  assign out_ctrl      = head_ctrl_q;
  assign occupancy     = state_q;

  // Skid mode breaks the out_ready -> in_ready path; pass mode allows same-cycle replacement.
  if (SKID != 0) begin : g_skid
    assign in_ready = in_ready_q & ~rst;
  end else begin : g_pass
    assign in_ready = ~rst & (~out_valid_raw | (out_ready & ~hold));
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      head_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d     = ONE;
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
          end else if (in_xfer) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_xfer) begin
            state_d     = EMPTY;
            head_ctrl_d = '0;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d     = ONE;
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(in_xfer && (state_q == TWO)));
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt #(.W(PIPE_PERF_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid_raw & (hold | ~out_ready)),
    .cnt (perf_stall_cnt)
  );

  pipe_perf_cnt #(.W(PIPE_PERF_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((state_q == EMPTY) & ~rst),
    .cnt (perf_bubble_cnt)
  );

  // Only flushes that actually kill a held beat are counted.
  pipe_perf_cnt #(.W(PIPE_FLUSH_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush & out_valid_raw),
    .cnt (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance (a) and SKID=0 instance (b) with FIFO scoreboards.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        hold = 1'b0;

  logic        in_valid_a = 1'b0, out_ready_a = 1'b0, in_ready_a, out_valid_a;
  logic [63:0] in_data_a = '0, out_data_a;
  logic [7:0]  in_ctrl_a = '0, out_ctrl_a;
  logic [1:0]  occ_a;

  logic        in_valid_b = 1'b0, out_ready_b = 1'b0, in_ready_b, out_valid_b;
  logic [63:0] in_data_b = '0, out_data_b;
  logic [7:0]  in_ctrl_b = '0, out_ctrl_b;
  logic [1:0]  occ_b;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_a, bubble_a, stall_b, bubble_b;
  logic [15:0] flushc_a, flushc_b;
`endif

  int checks = 0;
  int errors = 0;
  int n_out_a = 0;
  int n_out_b = 0;
  logic [71:0] q_a[$];
  logic [71:0] q_b[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .hold      (hold),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_data   (in_data_a),
    .in_ctrl   (in_ctrl_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_data  (out_data_a),
    .out_ctrl  (out_ctrl_a),
    .occupancy (occ_a)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt  (stall_a),
    .perf_bubble_cnt (bubble_a),
    .perf_flush_cnt  (flushc_a)
`endif
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .hold      (hold),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data_b),
    .in_ctrl   (in_ctrl_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_data  (out_data_b),
    .out_ctrl  (out_ctrl_b),
    .occupancy (occ_b)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt  (stall_b),
    .perf_bubble_cnt (bubble_b),
    .perf_flush_cnt  (flushc_b)
`endif
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: flush/rst drop every queued beat, including one offered that cycle.
  always @(negedge clk) begin
    if (rst || flush) begin
      q_a.delete();
    end else begin
      if (out_valid_a && out_ready_a) begin
        check("a_beat_expected", 72'(q_a.size() != 0), 72'd1);
        if (q_a.size() != 0) begin
          logic [71:0] e;
          e = q_a.pop_front();
          check("a_out_data", 72'(out_data_a), 72'(e[71:8]));
          check("a_out_ctrl", 72'(out_ctrl_a), 72'(e[7:0]));
        end
        n_out_a++;
      end
      if (in_valid_a && in_ready_a) q_a.push_back({in_data_a, in_ctrl_a});
    end
  end

  always @(negedge clk) begin
    if (rst || flush) begin
      q_b.delete();
    end else begin
      if (out_valid_b && out_ready_b) begin
        check("b_beat_expected", 72'(q_b.size() != 0), 72'd1);
        if (q_b.size() != 0) begin
          logic [71:0] e;
          e = q_b.pop_front();
          check("b_out_data", 72'(out_data_b), 72'(e[71:8]));
          check("b_out_ctrl", 72'(out_ctrl_b), 72'(e[7:0]));
        end
        n_out_b++;
      end
      if (in_valid_b && in_ready_b) q_b.push_back({in_data_b, in_ctrl_b});
    end
  end

  initial begin
    int n0;
    int idx;
    int stall;
    logic b_full;
    logic exp_acc;

    // Reset with an offered beat
    in_valid_a = 1'b1;
    in_data_a  = 64'h55;
    in_ctrl_a  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", 72'(in_ready_a), 72'd0);
      check("rst_out_valid", 72'(out_valid_a), 72'd0);
      check("rst_out_ctrl", 72'(out_ctrl_a), 72'd0);
    end
    check("rst_out_data", 72'(out_data_a), 72'd0);
    check("rst_occ", 72'(occ_a), 72'd0);
    rst = 1'b0;
    in_valid_a = 1'b0;
    #1;
    check("rel_in_ready_a", 72'(in_ready_a), 72'd1);
    check("rel_in_ready_b", 72'(in_ready_b), 72'd1);

    // Streaming, 1-cycle latency, no bubbles
    out_ready_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 64'h100 + 64'(i);
      in_ctrl_a  = 8'(i + 1);
      tick();
      check("stream_valid", 72'(out_valid_a), 72'd1);
      check("stream_data", 72'(out_data_a), 72'h100 + 72'(i));
    end
    in_valid_a = 1'b0;
    tick();
    check("stream_empty_valid", 72'(out_valid_a), 72'd0);
    check("stream_empty_ctrl", 72'(out_ctrl_a), 72'd0);
    check("stream_count", 72'(n_out_a), 72'd10);

    // Backpressure fills the skid entry
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 64'hA; in_ctrl_a = 8'h0A;
    tick();
    in_data_a = 64'hB; in_ctrl_a = 8'h0B;
    tick();
    check("bp_occ2", 72'(occ_a), 72'd2);
    check("bp_in_ready", 72'(in_ready_a), 72'd0);
    check("bp_head", 72'(out_data_a), 72'hA);
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    tick();
    check("bp_occ1", 72'(occ_a), 72'd1);
    check("bp_second", 72'(out_data_a), 72'hB);
    check("bp_in_ready_back", 72'(in_ready_a), 72'd1);
    tick();
    check("bp_drained", 72'(occ_a), 72'd0);

    // Flush from TWO, then from ONE with a beat that would be accepted
    n0 = n_out_a;
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 64'hE1; in_ctrl_a = 8'h11;
    tick();
    in_data_a = 64'hE2; in_ctrl_a = 8'h22;
    tick();
    check("fl_occ2", 72'(occ_a), 72'd2);
    flush = 1'b1; in_data_a = 64'hC; in_ctrl_a = 8'h0C;
    tick();
    flush = 1'b0; in_valid_a = 1'b0;
    check("fl_occ0", 72'(occ_a), 72'd0);
    check("fl_out_valid", 72'(out_valid_a), 72'd0);
    check("fl_out_ctrl", 72'(out_ctrl_a), 72'd0);
    check("fl_data_kept", 72'(out_data_a), 72'hE1);
    check("fl_in_ready", 72'(in_ready_a), 72'd1);
    in_valid_a = 1'b1; in_data_a = 64'hF0; in_ctrl_a = 8'h5A;
    tick();
    check("fl1_occ1", 72'(occ_a), 72'd1);
    flush = 1'b1; in_data_a = 64'hC; in_ctrl_a = 8'h0C;
    tick();
    flush = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    check("fl1_occ0", 72'(occ_a), 72'd0);
    check("fl1_data_kept", 72'(out_data_a), 72'hF0);
    check("fl1_out_ctrl", 72'(out_ctrl_a), 72'd0);
    tick();
    tick();
    check("fl_no_emit_valid", 72'(out_valid_a), 72'd0);
    check("fl_no_emit_count", 72'(n_out_a), 72'(n0));

    // Hold blocks dequeue; beat emitted exactly once afterwards
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 64'hD; in_ctrl_a = 8'h33;
    tick();
    in_valid_a = 1'b0; hold = 1'b1; out_ready_a = 1'b1;
    n0 = n_out_a;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_out_valid", 72'(out_valid_a), 72'd0);
      check("hold_data", 72'(out_data_a), 72'hD);
      check("hold_occ", 72'(occ_a), 72'd1);
    end
    hold = 1'b0;
    tick();
    check("hold_release_occ", 72'(occ_a), 72'd0);
    tick();
    check("hold_emit_once", 72'(n_out_a), 72'(n0 + 1));

    // SKID=0: in_ready follows out_ready in the same cycle once the head is full
    idx = 0;
    stall = 0;
    b_full = 1'b0;
    for (int c = 0; c < 16; c++) begin
      out_ready_b = ((c % 3) != 0);
      in_valid_b = 1'b1;
      in_data_b = 64'h200 + 64'(idx);
      in_ctrl_b = 8'(idx + 8'h40);
      #1;
      exp_acc = !b_full || out_ready_b;
      check("b_in_ready", 72'(in_ready_b), 72'(exp_acc));
      if (b_full && !out_ready_b) stall++;
      tick();
      if (exp_acc) begin
        idx++;
        b_full = 1'b1;
      end
    end
`ifdef PIPE_STAGE_PERF_EN
    check("b_perf_stall", 72'(stall_b), 72'(stall));
`endif
    in_valid_b = 1'b0;
    out_ready_b = 1'b1;
    tick();
    tick();
    check("b_occ_end", 72'(occ_b), 72'd0);
    check("b_count", 72'(n_out_b), 72'(idx));
    check("b_q_empty", 72'(q_b.size()), 72'd0);
    check("a_q_empty", 72'(q_a.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
